// File: rtl/mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the sequential multiply controller:
//   - default datapath / iteration counter widths
//   - controller state encoding
//   - operation codes understood by the shared ALU
//   - direction codes understood by the shared barrel Shifter
//   - helper that selects the partial product term for one iteration
// -----------------------------------------------------------------------------
package mul_seq_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADD,
    SHL,
    SHR,
    DONE
  } state_t;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam logic SFT_LEFT  = 1'b1;
  localparam logic SFT_RIGHT = 1'b0;

  // The multiplicand is added into the accumulator only when the current
  // multiplier LSB is set; otherwise the ALU adds zero.
  function automatic logic [DATA_W_DEF-1:0] partial_term(
    input logic                  mult_bit,
    input logic [DATA_W_DEF-1:0] multiplicand
  );
    return mult_bit ? multiplicand : '0;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Multi-cycle 32x32 unsigned multiplier (low 32 bits kept) built by
// sequencing an external shared ALU and barrel Shifter with the classic
// shift-and-add algorithm: per iteration ADD (P += Q[0] ? M : 0), SHL
// (M <<= 1), SHR (Q >>= 1).
//
// Build option:
//   MUL_SEQ_EARLY_TERM_EN - when defined, the job finishes as soon as the
//                           shifted multiplier becomes zero instead of
//                           always running all 32 iterations.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_valid/start_ready  request handshake (ready only in IDLE)
//   in_a, in_b               multiplicand / multiplier, captured on handshake
//   out_valid/out_ready      response handshake (valid only in DONE)
//   product                  low 32 bits of in_a*in_b, 0 when not valid
//   alu_*                    drive / result of the shared ALU
//   sft_*                    drive / result of the shared Shifter
// -----------------------------------------------------------------------------
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] product,

  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_invert_a,
  output logic              alu_invert_b,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,

  output logic              sft_left_right,
  output logic [CNT_W-1:0]  sft_shamt,
  output logic [DATA_W-1:0] sft_src,
  input  logic [DATA_W-1:0] sft_result
);

  state_t            state;
  logic [DATA_W-1:0] p_reg;
  logic [DATA_W-1:0] m_reg;
  logic [DATA_W-1:0] q_reg;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;

  // The ALU is only ever used for plain addition.
  assign alu_invert_a = 1'b0;
  assign alu_invert_b = 1'b0;

  // Decide in SHR whether this iteration is the final one. The normal build
  // always runs the full count; the early-termination build also stops once
  // no set multiplier bits remain, since further ADDs would only add zero.
  always_comb begin
    last_iter = (cnt == CNT_W'(DATA_W - 1));
`ifdef MUL_SEQ_EARLY_TERM_EN
    if (sft_result == '0) begin
      last_iter = 1'b1;
    end
`else
    last_iter = last_iter;
`endif
  end

  // Single FSM block. All ALU/Shifter drives are registered: they are loaded
  // on the edge that enters the state using them, and cleared on every other
  // edge so they read zero outside their active state. Values loaded on entry
  // use the register contents as they will be after that same edge (e.g. the
  // freshly shifted Q coming back from the Shifter when SHR loops to ADD).
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      p_reg          <= '0;
      m_reg          <= '0;
      q_reg          <= '0;
      cnt            <= '0;
      start_ready    <= 1'b1;
      out_valid      <= 1'b0;
      product        <= '0;
      alu_src1       <= '0;
      alu_src2       <= '0;
      alu_operation  <= OP_AND;
      sft_src        <= '0;
      sft_left_right <= SFT_RIGHT;
      sft_shamt      <= '0;
    end else begin
      alu_src1       <= '0;
      alu_src2       <= '0;
      alu_operation  <= OP_AND;
      sft_src        <= '0;
      sft_left_right <= SFT_RIGHT;
      sft_shamt      <= '0;

      case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            m_reg         <= in_a;
            q_reg         <= in_b;
            p_reg         <= '0;
            cnt           <= '0;
            start_ready   <= 1'b0;
            state         <= ADD;
            alu_src1      <= '0;
            alu_src2      <= partial_term(in_b[0], in_a);
            alu_operation <= OP_ADD;
          end
        end

        ADD: begin
          p_reg          <= alu_result;
          state          <= SHL;
          sft_src        <= m_reg;
          sft_left_right <= SFT_LEFT;
          sft_shamt      <= CNT_W'(1);
        end

        SHL: begin
          m_reg          <= sft_result;
          state          <= SHR;
          sft_src        <= q_reg;
          sft_left_right <= SFT_RIGHT;
          sft_shamt      <= CNT_W'(1);
        end

        SHR: begin
          q_reg <= sft_result;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= p_reg;
          end else begin
            state         <= ADD;
            alu_src1      <= p_reg;
            alu_src2      <= partial_term(sft_result[0], m_reg);
            alu_operation <= OP_ADD;
          end
        end

        DONE: begin
          // A start request in this cycle is deliberately not taken:
          // start_ready only rises once IDLE has been re-entered.
          if (out_valid && out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            product     <= '0;
            start_ready <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          out_valid   <= 1'b0;
          product     <= '0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
